// File: rtl/timebase_gen.sv
// Timebase generator: divides CLK into a tick enable, a blink square wave with
// its toggle pulses, and a modulo-TICK_WRAP tick counter with a carry pulse.
module timebase_gen #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1,
  parameter int BLINK_DIV = 4,
  parameter int FAST_MUL  = 8,
  parameter int TICK_WRAP = 60
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         RUN,
  input  logic                         CLR,
  input  logic                         FAST,
  output logic                         EN_TICK,
  output logic                         EN_BLINK,
  output logic                         SIG_BLINK,
  output logic [$clog2(TICK_WRAP)-1:0] TICK_CNT,
  output logic                         EN_WRAP
);

  localparam int PERIOD = CLK_HZ / TICK_HZ;
  localparam int CW     = $clog2(PERIOD);
  localparam int TW     = $clog2(TICK_WRAP);
  localparam int STEP   = PERIOD / BLINK_DIV;

  localparam logic [CW-1:0] TERM_SLOW = CW'(PERIOD - 1);
  localparam logic [CW-1:0] TERM_FAST = CW'(PERIOD / FAST_MUL - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_WRAP - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          sig_blink_q, sig_blink_d;

  logic          active_s;
  logic [CW-1:0] term_s;
  logic          at_term_s;
  logic          toggle_pt_s;
  logic          en_tick_s;
  logic          en_blink_s;
  logic          en_wrap_s;

  // Pulse decode; >= lets a FAST rise above the new terminal still emit one tick.
  always_comb begin
    active_s    = RST & RUN & ~CLR;
    term_s      = FAST ? TERM_FAST : TERM_SLOW;
    at_term_s   = (cnt_q >= term_s);
    toggle_pt_s = 1'b0;
    for (int k = 1; k <= BLINK_DIV; k++) begin
      if (cnt_q == CW'(k * STEP - 1)) begin
        toggle_pt_s = 1'b1;
      end else begin
        toggle_pt_s = toggle_pt_s;
      end
    end
    en_tick_s  = active_s & at_term_s;
    en_blink_s = active_s & ~FAST & toggle_pt_s;
    en_wrap_s  = en_tick_s & (tick_cnt_q == TICK_LAST);
  end

  // Next-state: CLR beats RUN beats FAST; RUN=0 freezes everything.
  always_comb begin
    cnt_d       = cnt_q;
    tick_cnt_d  = tick_cnt_q;
    sig_blink_d = sig_blink_q;
    if (CLR) begin
      cnt_d       = {CW{1'b0}};
      tick_cnt_d  = {TW{1'b0}};
      sig_blink_d = 1'b0;
    end else if (RUN) begin
      if (at_term_s) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
      if (en_tick_s) begin
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = {TW{1'b0}};
        end else begin
          tick_cnt_d = tick_cnt_q + TICK_ONE;
        end
      end else begin
        tick_cnt_d = tick_cnt_q;
      end
      if (FAST) begin
        sig_blink_d = 1'b1;
      end else if (en_blink_s) begin
        sig_blink_d = ~sig_blink_q;
      end else begin
        sig_blink_d = sig_blink_q;
      end
    end else begin
      cnt_d       = cnt_q;
      tick_cnt_d  = tick_cnt_q;
      sig_blink_d = sig_blink_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q       <= {CW{1'b0}};
      tick_cnt_q  <= {TW{1'b0}};
      sig_blink_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      sig_blink_q <= sig_blink_d;
    end
  end

  assign EN_TICK   = en_tick_s;
  assign EN_BLINK  = en_blink_s;
  assign EN_WRAP   = en_wrap_s;
  assign SIG_BLINK = sig_blink_q;
  assign TICK_CNT  = tick_cnt_q;

endmodule

// File: tb/tb_timebase_gen.sv
// Self-checking bench for timebase_gen with small parameters (16-cycle period).
module tb_timebase_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RUN = 1'b0;
  logic       CLR = 1'b0;
  logic       FAST = 1'b0;
  logic       EN_TICK, EN_BLINK, SIG_BLINK, EN_WRAP;
  logic [1:0] TICK_CNT;

  int vectors = 0;
  int errors  = 0;

  // Reference state: values the registers hold after the latest rising edge.
  int m_cnt  = 0;
  int m_tick = 0;
  int m_sig  = 0;

  timebase_gen #(
    .CLK_HZ(16), .TICK_HZ(1), .BLINK_DIV(4), .FAST_MUL(4), .TICK_WRAP(3)
  ) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .CLR(CLR), .FAST(FAST),
    .EN_TICK(EN_TICK), .EN_BLINK(EN_BLINK), .SIG_BLINK(SIG_BLINK),
    .TICK_CNT(TICK_CNT), .EN_WRAP(EN_WRAP)
  );

  always #5 CLK = ~CLK;

  function automatic logic [5:0] exp_vec();
    int  term;
    logic act, t, b, w;
    term = FAST ? 3 : 15;
    act  = RST && RUN && !CLR;
    t    = act && (m_cnt >= term);
    b    = act && !FAST && ((m_cnt + 1) % 4 == 0);
    w    = t && (m_tick == 2);
    return {t, b, w, 1'(m_sig), 2'(m_tick)};
  endfunction

  function automatic logic [5:0] got_vec();
    return {EN_TICK, EN_BLINK, EN_WRAP, SIG_BLINK, TICK_CNT};
  endfunction

  task automatic model_edge();
    logic [5:0] e;
    e = exp_vec();
    if (!RST || CLR) begin
      m_cnt = 0; m_tick = 0; m_sig = 0;
    end else if (RUN) begin
      m_cnt = e[5] ? 0 : m_cnt + 1;
      if (e[5]) m_tick = (m_tick + 1) % 3;
      if (FAST) m_sig = 1;
      else if (e[4]) m_sig = 1 - m_sig;
    end
  endtask

  task automatic next_edge();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      vectors++;
      if (got_vec() !== 6'b0) begin
        errors++; $display("FAIL reset cyc %0d got %b exp %b", i, got_vec(), 6'b0);
      end
    end
    RST = 1'b1;
    next_edge();
  endtask

  task automatic test_run48();
    RUN = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge CLK);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL run48 cyc %0d got %b exp %b", i, got_vec(), exp_vec());
      end
      vectors++;
      if (EN_TICK !== (i % 16 == 15) || EN_WRAP !== (i == 47) ||
          SIG_BLINK !== ((i % 8) >= 4) || EN_BLINK !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL run48_sched cyc %0d got tick %b wrap %b sig %b blink %b",
                 i, EN_TICK, EN_WRAP, SIG_BLINK, EN_BLINK);
      end
      next_edge();
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i < 40 && m_cnt != 6; i++) next_edge();
    RUN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      vectors++;
      if (got_vec() !== exp_vec() || EN_TICK || EN_BLINK || EN_WRAP) begin
        errors++; $display("FAIL pause cyc %0d got %b exp %b", i, got_vec(), exp_vec());
      end
      next_edge();
    end
    RUN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      vectors++;
      if (got_vec() !== exp_vec() || EN_BLINK !== (i == 1)) begin
        errors++; $display("FAIL resume cyc %0d got %b exp %b", i, got_vec(), exp_vec());
      end
      next_edge();
    end
  endtask

  task automatic test_fast();
    for (int i = 0; i < 40 && m_cnt != 10; i++) next_edge();
    FAST = 1'b1;
    for (int k = 0; k < 13; k++) begin
      @(negedge CLK);
      vectors++;
      if (got_vec() !== exp_vec() || EN_TICK !== (k % 4 == 0) || EN_BLINK !== 1'b0 ||
          (k > 0 && SIG_BLINK !== 1'b1)) begin
        errors++; $display("FAIL fast cyc %0d got %b exp %b", k, got_vec(), exp_vec());
      end
      next_edge();
    end
    FAST = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL fast_exit cyc %0d got %b exp %b", k, got_vec(), exp_vec());
      end
      next_edge();
    end
  endtask

  task automatic test_clear();
    int n = 0;
    while (!(m_cnt == 15 && m_tick == 2) && n < 200) begin next_edge(); n++; end
    vectors++;
    if (n >= 200) begin
      errors++; $display("FAIL clear_setup got cnt %0d tick %0d exp 15 2", m_cnt, m_tick);
    end
    CLR = 1'b1;
    @(negedge CLK);
    vectors++;
    if (EN_TICK !== 1'b0 || EN_WRAP !== 1'b0 || EN_BLINK !== 1'b0) begin
      errors++; $display("FAIL clear_pulses got %b exp 000", {EN_TICK, EN_BLINK, EN_WRAP});
    end
    next_edge();
    CLR = 1'b0;
    @(negedge CLK);
    vectors++;
    if (TICK_CNT !== 2'd0 || SIG_BLINK !== 1'b0 || got_vec() !== exp_vec()) begin
      errors++; $display("FAIL clear_after got %b exp %b", got_vec(), exp_vec());
    end
    next_edge();
  endtask

  task automatic test_async_reset();
    int n = 0;
    int first = -1;
    while (!(m_cnt == 9 && m_tick != 0) && n < 100) begin next_edge(); n++; end
    vectors++;
    if (n >= 100 || TICK_CNT === 2'd0) begin
      errors++; $display("FAIL areset_setup got tick_cnt %0d exp nonzero", TICK_CNT);
    end
    #3;
    RST = 1'b0;
    m_cnt = 0; m_tick = 0; m_sig = 0;
    #1;
    vectors++;
    if (got_vec() !== 6'b0) begin
      errors++; $display("FAIL areset_async got %b exp %b", got_vec(), 6'b0);
    end
    #2;
    RST = 1'b1;
    next_edge();
    for (int j = 0; j < 20; j++) begin
      @(negedge CLK);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL areset_run cyc %0d got %b exp %b", j, got_vec(), exp_vec());
      end
      if (EN_TICK === 1'b1 && first < 0) first = j + 2;
      next_edge();
    end
    vectors++;
    if (first != 16) begin
      errors++; $display("FAIL areset_first_tick got %0d exp 16", first);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RUN = ($urandom % 8) != 0;
      CLR = ($urandom % 32) == 0;
      if ($urandom % 16 == 0) FAST = ~FAST;
      @(negedge CLK);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d run %b clr %b fast %b got %b exp %b",
                 i, RUN, CLR, FAST, got_vec(), exp_vec());
      end
      next_edge();
    end
  endtask

  initial begin
    test_reset();
    test_run48();
    test_pause();
    test_fast();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/timebase_gen.md
TIMEBASE_GEN -- requirements
Module: timebase_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1, nominal tick rate in Hz; PERIOD = CLK_HZ/TICK_HZ; CW = $clog2(PERIOD).
REQ-003 SHALL have parameter BLINK_DIV, default 4, blink toggles per tick period; even, >=2, PERIOD % BLINK_DIV == 0.
REQ-004 SHALL have parameter FAST_MUL, default 8, tick-rate multiplier in fast mode; PERIOD % FAST_MUL == 0, PERIOD/FAST_MUL >= 2.
REQ-005 SHALL have parameter TICK_WRAP, default 60, modulus of the tick counter, >=2; TW = $clog2(TICK_WRAP).
REQ-006 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-007 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port RUN  input  1  count enable; 0 = pause.
REQ-009 SHALL have port CLR  input  1  synchronous clear.
REQ-010 SHALL have port FAST  input  1  fast mode (tick period divided by FAST_MUL).
REQ-011 SHALL have port EN_TICK  output  1  one-cycle tick enable pulse.
REQ-012 SHALL have port EN_BLINK  output  1  one-cycle pulse at each blink toggle point.
REQ-013 SHALL have port SIG_BLINK  output  1  blink square wave, registered.
REQ-014 SHALL have port TICK_CNT  output  TW  tick count 0..TICK_WRAP-1, registered.
REQ-015 SHALL have port EN_WRAP  output  1  one-cycle carry pulse when TICK_CNT wraps.

Function
REQ-016 SHALL hold an internal counter cnt[CW-1:0]; TERM = PERIOD-1 when FAST=0, PERIOD/FAST_MUL-1 when FAST=1.
REQ-017 SHALL, when RUN=1 and CLR=0, set cnt to 0 if cnt >= TERM, else to cnt+1.
REQ-018 SHALL drive EN_TICK combinationally = RUN & ~CLR & (cnt >= TERM); the >= covers FAST rising while cnt exceeds the new TERM (one tick, then wrap to 0).
REQ-019 SHALL define toggle points cnt == k*PERIOD/BLINK_DIV - 1, k = 1..BLINK_DIV; EN_BLINK = RUN & ~CLR & ~FAST & (cnt at a toggle point).
REQ-020 SHALL invert SIG_BLINK on each cycle where EN_BLINK=1 (default params: 2 Hz, 50% duty, rising at 0.25 s).
REQ-021 SHALL, while FAST=1, force SIG_BLINK to 1 on the next edge and hold it there; on FAST falling, SIG_BLINK resumes toggling from 1 at the next toggle point.
REQ-022 SHALL increment TICK_CNT on each cycle with EN_TICK=1, wrapping TICK_WRAP-1 -> 0.
REQ-023 SHALL drive EN_WRAP combinationally = EN_TICK & (TICK_CNT == TICK_WRAP-1).
REQ-024 SHALL, when RUN=0 and CLR=0, hold cnt, SIG_BLINK and TICK_CNT, with EN_TICK, EN_BLINK and EN_WRAP low.
REQ-025 SHALL, when CLR=1 (priority over RUN and FAST), load cnt=0, TICK_CNT=0, SIG_BLINK=0 on the next edge, with all pulse outputs low in that cycle.
REQ-026 SHALL use unsigned arithmetic on CW/TW-bit vectors, with no overflow for any legal parameter set.

Reset
REQ-027 SHALL, on RST=0, immediately clear cnt, TICK_CNT and SIG_BLINK to 0 regardless of CLK; the pulse outputs are low throughout reset (they are derived from cleared state, or RUN gating suffices).
REQ-028 SHALL start counting from cnt=0 at the first rising edge after RST deasserts with RUN=1; reset mid-period discards the partial period.

Verification (CLK_HZ=16, TICK_HZ=1, BLINK_DIV=4, FAST_MUL=4, TICK_WRAP=3)
REQ-029 SHALL check: release reset, RUN=1 for 48 cycles -> EN_TICK at cycles 15,31,47; EN_BLINK at cnt=3,7,11,15; SIG_BLINK 0 for 4 cycles, 1 for 4 cycles; EN_WRAP only at cycle 47; TICK_CNT 0->1->2->0.
REQ-030 SHALL check: RUN=0 for 5 cycles at cnt=6 -> cnt, SIG_BLINK, TICK_CNT frozen, no pulses; RUN=1 -> EN_BLINK when cnt=7, one cycle after resume.
REQ-031 SHALL check: FAST=1 asserted at cnt=10 -> EN_TICK in that same cycle, cnt=0 next; thereafter EN_TICK every 4 cycles; SIG_BLINK=1 and EN_BLINK=0 throughout.
REQ-032 SHALL check: CLR=1 together with RUN=1 at cnt=15, TICK_CNT=2 -> no EN_TICK or EN_WRAP; next cycle cnt=0, TICK_CNT=0, SIG_BLINK=0.
REQ-033 SHALL check: RST=0 pulsed between clock edges at cnt=9 -> outputs clear asynchronously before the next edge; after release, first EN_TICK 16 cycles later.
